// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / duty decoder pair:
// state encoding, default widths and prescaler encoding.
package pwm_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DUTY_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // conf selects a tick every 2^conf clk cycles; 3 bits gives up to 128.
  localparam int CONF_W  = 3;
  localparam int PRESC_W = (1 << CONF_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RISE,
    ST_HIGH,
    ST_LOW
  } pwm_state_e;

  // Terminal count of the prescaler for a given conf value.
  function automatic logic [PRESC_W-1:0] presc_max(input logic [CONF_W-1:0] conf);
    return PRESC_W'((32'd1 << conf) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_duty_divider.sv
// Serial restoring divider: quotient = floor((hi << DUTY_W) / per),
// one quotient bit per clk. The operands travel with the result so a
// new start may be accepted on the same cycle the previous one finishes.
module pwm_duty_divider
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_hi,
  input  logic [CNT_W-1:0]  i_per,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot,
  output logic [CNT_W-1:0]  o_per,
  output logic [CNT_W-1:0]  o_hi
);

  localparam int IT_W = $clog2(DUTY_W + 1);

  logic [CNT_W:0]    r_rem;
  logic [CNT_W-1:0]  r_den;
  logic [CNT_W-1:0]  r_num;
  logic [DUTY_W-1:0] r_q;
  logic [IT_W-1:0]   r_iter;
  logic              r_run;
  logic              r_sat;
  logic              r_done;
  logic [DUTY_W-1:0] r_res_q;
  logic [CNT_W-1:0]  r_res_per;
  logic [CNT_W-1:0]  r_res_hi;

  logic [CNT_W:0]    w_rem_sh;
  logic [CNT_W:0]    w_den_ext;
  logic              w_ge;
  logic              w_last;
  logic [DUTY_W-1:0] w_q_next;

  // The remainder always stays below the divisor, so shifting out the
  // top bit loses nothing unless the saturate flag already overrides it.
  assign w_rem_sh  = {r_rem[CNT_W-1:0], 1'b0};
  assign w_den_ext = {1'b0, r_den};
  assign w_ge      = (w_rem_sh >= w_den_ext);
  assign w_q_next  = {r_q[DUTY_W-2:0], w_ge};
  assign w_last    = r_run && (r_iter == IT_W'(1));

  // The final iteration cycle is not busy: a new start may overlap it.
  assign o_busy = r_run && !w_last;
  assign o_done = r_done;
  assign o_quot = r_res_q;
  assign o_per  = r_res_per;
  assign o_hi   = r_res_hi;

  // Iterate, publish on the last step, reload on start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_den     <= '0;
      r_num     <= '0;
      r_q       <= '0;
      r_iter    <= '0;
      r_run     <= 1'b0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
      r_res_q   <= '0;
      r_res_per <= '0;
      r_res_hi  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_run <= 1'b0;
      end else begin
        if (r_run) begin
          r_rem  <= w_ge ? (w_rem_sh - w_den_ext) : w_rem_sh;
          r_q    <= w_q_next;
          r_iter <= r_iter - 1'b1;
          if (w_last) begin
            r_run     <= 1'b0;
            r_done    <= 1'b1;
            r_res_q   <= r_sat ? '1 : w_q_next;
            r_res_per <= r_den;
            r_res_hi  <= r_num;
          end
        end
        if (i_start) begin
          r_rem  <= {1'b0, i_hi};
          r_den  <= i_per;
          r_num  <= i_hi;
          r_q    <= '0;
          r_iter <= IT_W'(DUTY_W);
          r_run  <= 1'b1;
          // A quotient that would not fit (or a zero period) reads as all-ones.
          r_sat  <= (i_hi >= i_per);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures an incoming PWM waveform in prescaled ticks and reports
// period, high time and duty, plus timeout and overrun indications.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  input  logic [CONF_W-1:0] conf,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic [PRESC_W-1:0]     r_presc;
  logic [CONF_W-1:0]      r_conf;
  logic                   r_level;
  pwm_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi_cap;
  logic [DUTY_W-1:0]      r_duty;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_overrun;

  logic              w_sync;
  logic              w_conf_chg;
  logic              w_tick;
  logic              w_rise;
  logic              w_fall;
  logic              w_sat;
  pwm_state_e        w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_hi_cap_next;
  logic              w_div_start;
  logic              w_ovr;
  logic              w_to_evt;
  logic              w_div_abort;
  logic              w_div_busy;
  logic              w_div_done;
  logic [DUTY_W-1:0] w_div_quot;
  logic [CNT_W-1:0]  w_div_per;
  logic [CNT_W-1:0]  w_div_hi;
  logic              w_publish;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_conf_chg = (conf != r_conf);
  assign w_tick     = !w_conf_chg && (r_presc == presc_max(conf));
  // Edges compare the level sampled on this tick with the previous tick's.
  assign w_rise     = !r_level && w_sync;
  assign w_fall     = r_level && !w_sync;
  assign w_sat      = (r_cnt == CNT_MAX);

  // Synchroniser chain for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= pwm_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Prescaler, conf change tracking and tick-sampled pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_conf  <= '0;
      r_level <= 1'b0;
    end else begin
      r_conf <= conf;
      if (w_conf_chg || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_tick) begin
        r_level <= w_sync;
      end
    end
  end

  // Measurement FSM state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi_cap <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_hi_cap <= w_hi_cap_next;
    end
  end

  // Next-state logic: captures use the count before this tick's increment.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_hi_cap_next = r_hi_cap;
    w_div_start   = 1'b0;
    w_ovr         = 1'b0;
    w_to_evt      = 1'b0;
    if (!ena || w_conf_chg) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_WAIT_RISE;
          w_cnt_next   = '0;
        end
        ST_WAIT_RISE: begin
          if (w_tick && w_rise) begin
            w_cnt_next   = CNT_W'(1);
            w_state_next = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            if (w_sat) begin
              w_to_evt     = 1'b1;
              w_cnt_next   = '0;
              w_state_next = ST_WAIT_RISE;
            end else if (w_fall) begin
              w_hi_cap_next = r_cnt;
              w_cnt_next    = r_cnt + 1'b1;
              w_state_next  = ST_LOW;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            if (w_rise) begin
              // A capture that finds the divider mid-calculation is dropped,
              // but counting of the new period carries on regardless.
              if (w_div_busy) begin
                w_ovr = 1'b1;
              end else begin
                w_div_start = 1'b1;
              end
              w_cnt_next   = CNT_W'(1);
              w_state_next = ST_HIGH;
            end else if (w_sat) begin
              w_to_evt     = 1'b1;
              w_cnt_next   = '0;
              w_state_next = ST_WAIT_RISE;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign w_div_abort = !ena || w_conf_chg || w_to_evt;
  assign w_publish   = w_div_done && ena && !w_conf_chg && !w_to_evt;

  pwm_duty_divider #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_div_start),
    .i_abort (w_div_abort),
    .i_hi    (r_hi_cap),
    .i_per   (r_cnt),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot),
    .o_per   (w_div_per),
    .o_hi    (w_div_hi)
  );

  // Result registers: timeout report wins over a finishing division.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_ovr;
      if (w_to_evt) begin
        r_timeout <= 1'b1;
        r_period  <= CNT_MAX;
        r_high    <= w_sync ? CNT_MAX : '0;
        r_duty    <= w_sync ? '1 : '0;
        r_valid   <= 1'b1;
      end else if (w_publish) begin
        r_timeout <= 1'b0;
        r_period  <= w_div_per;
        r_high    <= w_div_hi;
        r_duty    <= w_div_quot;
        r_valid   <= 1'b1;
      end
    end
  end

  assign duty      = r_duty;
  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign overrun   = r_overrun;

endmodule
